uart_echo_responder: RTL
========================

// Module: uart_echo_responder
// PURPOSE
// - Far-end controller for the UART block's FIFO/handshake interface: commits received bytes into the RX FIFO,
//   drains the RX FIFO, writes each byte into the TX FIFO, and sequences UART_TX (pop, start, wait busy).
// - Sits beside the UART top-level; drives every enable the top leaves to external logic. Gives a byte-echo path.
// PARAMETERS
// - BUSY_TIMEOUT  16  max clks to wait for tx_busy rise after start_TX before flagging tx_error
// - COUNT_WIDTH   16  width of echo_count
// PORTS
// - clk               in   1   system clock (50MHz)
// - rst               in   1   asynchronous, active-high reset
// - eoc_flag          in   1   UART_RX end-of-character pulse; buffer_RX valid this cycle
// - rx_fifo_empty     in   1   RX FIFO empty
// - rx_fifo_full      in   1   RX FIFO full
// - rx_fifo_data_out  in   8   RX FIFO read data; valid 1 clk after rx_rd_en
// - tx_fifo_empty     in   1   TX FIFO empty
// - tx_fifo_full      in   1   TX FIFO full
// - tx_busy           in   1   UART_TX busy
// - rx_wr_en          out  1   RX FIFO write strobe (1 clk)
// - rx_rd_en          out  1   RX FIFO read strobe (1 clk)
// - tx_wr_en          out  1   TX FIFO write strobe (1 clk)
// - tx_fifo_data_in   out  8   TX FIFO write data
// - tx_rd_en          out  1   TX FIFO read strobe (1 clk)
// - start_TX          out  1   UART_TX start pulse (1 clk)
// - rx_overflow       out  1   sticky: byte dropped, RX FIFO full at eoc_flag
// - tx_error          out  1   sticky: tx_busy never rose within BUSY_TIMEOUT
// - echo_count        out  COUNT_WIDTH  bytes written to TX FIFO; wraps all-ones -> 0
// BEHAVIOUR
// - Reset: all outputs 0, both FSMs idle, timeout counter 0. Async assert; release is sync to clk.
// - Capture: eoc_flag at cycle N, !rx_fifo_full -> rx_wr_en=1 in N+1. Full -> no write, rx_overflow=1 from N+1.
// - Echo FSM: E_IDLE -> E_RD when !rx_fifo_empty && !tx_fifo_full (rx_rd_en=1 in E_RD).
//   E_RD -> E_WAIT (data settles) -> E_WR (tx_wr_en=1, tx_fifo_data_in=f(rx_fifo_data_out), echo_count++) -> E_IDLE.
//   Throughput 1 byte / 4 clks. tx_fifo_data_in holds last value outside E_WR.
// - TX FSM: T_IDLE -> T_POP when !tx_fifo_empty && !tx_busy (tx_rd_en=1).
//   T_POP -> T_LOAD (data_out settles) -> T_START (start_TX=1) -> T_WBUSY.
//   T_WBUSY: tx_busy=1 -> T_WDONE; BUSY_TIMEOUT clks without rise -> tx_error=1, T_IDLE. T_WDONE: tx_busy=0 -> T_IDLE.
// - FSMs run independently; rx_wr_en and rx_rd_en may assert in the same clk. Same for tx_wr_en and tx_rd_en.
// - Never: rx_rd_en when rx_fifo_empty; tx_wr_en when tx_fifo_full; tx_rd_en when tx_fifo_empty; start_TX while tx_busy.
// - Reset mid-operation aborts both FSMs; no strobes in the cycle after release. Sticky flags clear only on rst.
// CONFIGURATION
// - UART_ECHO_UPCASE_EN defined: f(x)=x-8'h20 for x in 8'h61..8'h7A (a-z -> A-Z), else f(x)=x.
// - Not defined: f(x)=x (verbatim echo). No other behaviour changes.
// TESTING
// - Reset 5 clks, then idle inputs (FIFOs empty, tx_busy=0) -> every strobe and flag stays 0 for 100 clks.
// - eoc_flag pulse, FIFO model returns 8'h41 -> rx_wr_en next clk; tx_wr_en with 8'h41; start_TX once; echo_count=1.
// - Byte 8'h62 -> tx_fifo_data_in=8'h42 with UART_ECHO_UPCASE_EN, 8'h62 without; 8'h7B unchanged in both builds.
// - rx_fifo_full=1 at eoc_flag -> no rx_wr_en, rx_overflow=1 and held until rst.
// - tx_busy held 0 after start_TX -> tx_error=1 after 16 clks, TX FSM idle; next byte pops normally.
// - 3 bytes queued, tx_fifo_full pulses 1 for 10 clks, rst asserted mid-transfer -> no writes while full, no illegal strobes,
//   all outputs 0 during reset.

Source files
------------

// File: rtl/uart_echo_responder.sv
// UART echo responder: capture strobe, RX->TX echo FSM, UART_TX sequencer.
// Optional build macro: UART_ECHO_UPCASE_EN (a-z folded to A-Z on echo).
module uart_echo_responder #(
    parameter int BUSY_TIMEOUT = 16,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   eoc_flag,
    input  logic                   rx_fifo_empty,
    input  logic                   rx_fifo_full,
    input  logic [7:0]             rx_fifo_data_out,
    input  logic                   tx_fifo_empty,
    input  logic                   tx_fifo_full,
    input  logic                   tx_busy,
    output logic                   rx_wr_en,
    output logic                   rx_rd_en,
    output logic                   tx_wr_en,
    output logic [7:0]             tx_fifo_data_in,
    output logic                   tx_rd_en,
    output logic                   start_TX,
    output logic                   rx_overflow,
    output logic                   tx_error,
    output logic [COUNT_WIDTH-1:0] echo_count
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        E_IDLE,
        E_RD,
        E_WAIT,
        E_WR
    } e_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_POP,
        T_LOAD,
        T_START,
        T_WBUSY,
        T_WDONE
    } t_state_t;

    e_state_t         e_q, e_d;
    t_state_t         t_q, t_d;
    logic             rx_wr_q, rx_wr_d;
    logic             ovf_q, ovf_d;
    logic             terr_q, terr_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [7:0]       data_q, data_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    function automatic logic [7:0] echo_map(input logic [7:0] x);
`ifdef UART_ECHO_UPCASE_EN
        if (x >= 8'h61 && x <= 8'h7A) begin
            return x - 8'h20;
        end
        return x;
`else
        return x;
`endif
    endfunction

    // Capture path: one-clock write strobe and sticky overflow.
    always_comb begin
        rx_wr_d = eoc_flag && !rx_fifo_full;
        ovf_d   = ovf_q | (eoc_flag && rx_fifo_full);
    end

    // Echo FSM next state; a full TX FIFO stalls the write stage.
    always_comb begin
        e_d = e_q;
        case (e_q)
            E_IDLE: if (!rx_fifo_empty && !tx_fifo_full) e_d = E_RD;
            E_RD:   e_d = rx_fifo_empty ? E_IDLE : E_WAIT;
            E_WAIT: e_d = E_WR;
            E_WR:   if (!tx_fifo_full) e_d = E_IDLE;
            default: e_d = E_IDLE;
        endcase
    end

    // Echo FSM outputs; strobes are gated by the FIFO flags they must respect.
    always_comb begin
        rx_rd_en = (e_q == E_RD) && !rx_fifo_empty;
        tx_wr_en = (e_q == E_WR) && !tx_fifo_full;
    end

    // Echo datapath: latch mapped byte once read data has settled, count writes.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (e_q == E_WAIT) data_d = echo_map(rx_fifo_data_out);
        if (tx_wr_en)      cnt_d  = cnt_q + 1'b1;
    end

    // TX FSM next state, busy-rise timeout and sticky error.
    always_comb begin
        t_d    = t_q;
        tmr_d  = '0;
        terr_d = terr_q;
        case (t_q)
            T_IDLE:  if (!tx_fifo_empty && !tx_busy) t_d = T_POP;
            T_POP:   t_d = tx_fifo_empty ? T_IDLE : T_LOAD;
            T_LOAD:  t_d = T_START;
            T_START: if (!tx_busy) t_d = T_WBUSY;
            T_WBUSY: begin
                if (tx_busy) begin
                    t_d = T_WDONE;
                end else if (tmr_q == TMO_LAST) begin
                    t_d    = T_IDLE;
                    terr_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            T_WDONE: if (!tx_busy) t_d = T_IDLE;
            default: t_d = T_IDLE;
        endcase
    end

    // TX FSM outputs.
    always_comb begin
        tx_rd_en = (t_q == T_POP) && !tx_fifo_empty;
        start_TX = (t_q == T_START) && !tx_busy;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q     <= E_IDLE;
            t_q     <= T_IDLE;
            rx_wr_q <= 1'b0;
            ovf_q   <= 1'b0;
            terr_q  <= 1'b0;
            tmr_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            e_q     <= e_d;
            t_q     <= t_d;
            rx_wr_q <= rx_wr_d;
            ovf_q   <= ovf_d;
            terr_q  <= terr_d;
            tmr_q   <= tmr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rx_wr_en        = rx_wr_q;
    assign rx_overflow     = ovf_q;
    assign tx_error        = terr_q;
    assign tx_fifo_data_in = data_q;
    assign echo_count      = cnt_q;

endmodule
